// File: rtl/ambiente_robo.sv
// rtl/ambiente_robo.sv - grid-world environment model closing the loop around the wall-following robot controller
module ambiente_robo #(
    parameter int LARG = 8,
    parameter int ALT  = 8,
    parameter int X0   = 0,
    parameter int Y0   = 0,
    parameter int DIR0 = 0,
    parameter logic [LARG*ALT-1:0] MAPA = '0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        avancar,
    input  logic        girar,
    output logic        head,
    output logic        left,
    output logic [3:0]  pos_x,
    output logic [3:0]  pos_y,
    output logic [1:0]  direcao,
    output logic [15:0] passos,
    output logic        colisao
);

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // Out-of-grid neighbours count as walls, so a move can never wrap the 4-bit position.
    function automatic logic bloqueado(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
        int nx;
        int ny;
        int idx;
        logic [LARG*ALT-1:0] deslocado;
        nx = int'(x);
        ny = int'(y);
        case (d)
            DIR_N:   ny = ny - 1;
            DIR_E:   nx = nx + 1;
            DIR_S:   ny = ny + 1;
            default: nx = nx - 1;
        endcase
        if (nx < 0 || nx >= LARG || ny < 0 || ny >= ALT) begin
            return 1'b1;
        end
        idx = ny * LARG + nx;
        deslocado = MAPA >> idx;
        return deslocado[0];
    endfunction

    assign head = bloqueado(pos_x, pos_y, direcao);
    assign left = bloqueado(pos_x, pos_y, direcao + 2'd3);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pos_x   <= 4'(X0);
            pos_y   <= 4'(Y0);
            direcao <= 2'(DIR0);
            passos  <= 16'd0;
            colisao <= 1'b0;
        end else if (girar) begin
            direcao <= direcao + 2'd1;
        end else if (avancar) begin
            if (!head) begin
                case (direcao)
                    DIR_N:   pos_y <= pos_y - 4'd1;
                    DIR_E:   pos_x <= pos_x + 4'd1;
                    DIR_S:   pos_y <= pos_y + 4'd1;
                    default: pos_x <= pos_x - 4'd1;
                endcase
                if (passos != 16'hFFFF) begin
                    passos <= passos + 16'd1;
                end
            end else begin
                colisao <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ambiente_robo.sv
// tb/tb_ambiente_robo.sv - directed self-checking bench for ambiente_robo
module tb_ambiente_robo;

    logic        clock;
    logic        reset;
    logic        a_av, a_gi, b_av, b_gi;
    logic        a_head, a_left, a_col;
    logic [3:0]  a_x, a_y;
    logic [1:0]  a_dir;
    logic [15:0] a_passos;
    logic        b_head, b_left, b_col;
    logic [3:0]  b_x, b_y;
    logic [1:0]  b_dir;
    logic [15:0] b_passos;

    int n_cmp = 0;
    int n_err = 0;

    ambiente_robo dut_a (
        .clock(clock), .reset(reset), .avancar(a_av), .girar(a_gi),
        .head(a_head), .left(a_left), .pos_x(a_x), .pos_y(a_y),
        .direcao(a_dir), .passos(a_passos), .colisao(a_col)
    );

    // wall at (2,0), starting at (0,0) facing East
    ambiente_robo #(.DIR0(1), .MAPA(64'h4)) dut_b (
        .clock(clock), .reset(reset), .avancar(b_av), .girar(b_gi),
        .head(b_head), .left(b_left), .pos_x(b_x), .pos_y(b_y),
        .direcao(b_dir), .passos(b_passos), .colisao(b_col)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        reset = 1'b0;
        a_av = 0; a_gi = 0; b_av = 0; b_gi = 0;
        #12;
        chk("rst_x", int'(a_x), 0);
        chk("rst_y", int'(a_y), 0);
        chk("rst_dir", int'(a_dir), 0);
        chk("rst_head", int'(a_head), 1);
        chk("rst_left", int'(a_left), 1);
        chk("rst_passos", int'(a_passos), 0);
        chk("rst_col", int'(a_col), 0);
        @(negedge clock);
        reset = 1'b1;

        // rotation and 3->0 wrap
        a_gi = 1;
        cyc(1);
        chk("gir1_dir", int'(a_dir), 1);
        chk("gir1_head", int'(a_head), 0);
        chk("gir1_left", int'(a_left), 1);
        cyc(2);
        chk("gir3_dir", int'(a_dir), 3);
        cyc(1);
        chk("gir_wrap_dir", int'(a_dir), 0);

        // run east to the border, then bump
        cyc(1);
        a_gi = 0; a_av = 1;
        cyc(7);
        chk("east7_x", int'(a_x), 7);
        chk("east7_passos", int'(a_passos), 7);
        chk("east7_head", int'(a_head), 1);
        chk("east7_col", int'(a_col), 0);
        cyc(1);
        chk("bump_x", int'(a_x), 7);
        chk("bump_passos", int'(a_passos), 7);
        chk("bump_col", int'(a_col), 1);

        // walk to (3,3) facing N
        a_av = 0; a_gi = 1; cyc(1);
        a_gi = 0; a_av = 1; cyc(3);
        a_av = 0; a_gi = 1; cyc(1);
        a_gi = 0; a_av = 1; cyc(4);
        a_av = 0; a_gi = 1; cyc(1);
        chk("walk_x", int'(a_x), 3);
        chk("walk_y", int'(a_y), 3);
        chk("walk_dir", int'(a_dir), 0);
        chk("walk_passos", int'(a_passos), 14);

        // girar wins over avancar
        a_av = 1; a_gi = 1; cyc(1);
        chk("both_x", int'(a_x), 3);
        chk("both_y", int'(a_y), 3);
        chk("both_dir", int'(a_dir), 1);
        chk("both_passos", int'(a_passos), 14);
        chk("col_sticky", int'(a_col), 1);

        // five more moves, then async reset between edges
        a_gi = 0; a_av = 1; cyc(4);
        a_av = 0; a_gi = 1; cyc(1);
        a_gi = 0; a_av = 1; cyc(1);
        chk("pre_rst_x", int'(a_x), 7);
        chk("pre_rst_y", int'(a_y), 4);
        chk("pre_rst_passos", int'(a_passos), 19);
        reset = 1'b0;
        #1;
        chk("arst_x", int'(a_x), 0);
        chk("arst_y", int'(a_y), 0);
        chk("arst_dir", int'(a_dir), 0);
        chk("arst_passos", int'(a_passos), 0);
        chk("arst_col", int'(a_col), 0);
        chk("arst_head", int'(a_head), 1);
        cyc(1);
        chk("arst_hold_x", int'(a_x), 0);
        a_av = 0;
        @(negedge clock);
        reset = 1'b1;

        // map with a wall at (2,0)
        #1;
        chk("b_rst_head", int'(b_head), 0);
        chk("b_rst_left", int'(b_left), 1);
        b_av = 1; cyc(1);
        chk("b_step_x", int'(b_x), 1);
        chk("b_step_head", int'(b_head), 1);
        cyc(1);
        chk("b_bump_x", int'(b_x), 1);
        chk("b_bump_col", int'(b_col), 1);
        chk("b_bump_passos", int'(b_passos), 1);
        b_av = 0; b_gi = 1; cyc(1);
        b_gi = 0; b_av = 1; cyc(1);
        b_av = 0; b_gi = 1; cyc(3);
        b_gi = 0; b_av = 1; cyc(1);
        chk("b_21_x", int'(b_x), 2);
        chk("b_21_y", int'(b_y), 1);
        chk("b_21E_left", int'(b_left), 1);
        chk("b_21E_head", int'(b_head), 0);
        b_av = 0; b_gi = 1; cyc(1);
        b_gi = 0;
        chk("b_21S_dir", int'(b_dir), 2);
        chk("b_21S_left", int'(b_left), 0);
        chk("b_21S_head", int'(b_head), 0);
        chk("b_passos", int'(b_passos), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
